// File: rtl/dc_sync_filter.sv
// Multi-bit level synchronizer with optional per-bit persistence filter and edge pulses.
// Each bit is synchronized independently; there is no coherency between bits.
module dc_sync_filter #(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int               FILTER_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("dc_sync_filter: STAGES must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("dc_sync_filter: WIDTH must be >= 1");
    end
    if (FILTER_CYCLES < 0) begin : g_bad_filter
      $error("dc_sync_filter: FILTER_CYCLES must be >= 0");
    end
  endgenerate

  // Plain flop chain: nothing may sit between stages or metastability resolution time is lost.
  logic [WIDTH-1:0] sync_reg [STAGES];
  logic [WIDTH-1:0] synced;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_reg[k] <= RESET_VALUE;
      end
    end else begin
      sync_reg[0] <= d_in;
      for (int k = 1; k < STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
    end
  end

  assign synced = sync_reg[STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign d_out = synced;
    end else begin : g_filter
      localparam int             CNT_W    = $clog2(FILTER_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

      logic [WIDTH-1:0] out_bits;

      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             out_reg;
        logic             out_next;

        // Any sample matching the current output restarts the run, so glitches never accumulate.
        always_comb begin
          cnt_next = cnt_reg;
          out_next = out_reg;
          if (synced[gi] == out_reg) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_LAST) begin
            out_next = synced[gi];
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            cnt_reg <= '0;
            out_reg <= RESET_VALUE[gi];
          end else begin
            cnt_reg <= cnt_next;
            out_reg <= out_next;
          end
        end

        assign out_bits[gi] = out_reg;

        a_cnt_bound : assert property (@(posedge clk) disable iff (!rstn) cnt_reg <= CNT_LAST)
          else $error("dc_sync_filter: filter counter exceeded its terminal value");
      end

      assign d_out = out_bits;
    end
  endgenerate

  // History starts equal to d_out, so leaving reset never produces a spurious pulse.
  logic [WIDTH-1:0] hist_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_reg <= RESET_VALUE;
    end else begin
      hist_reg <= d_out;
    end
  end

  assign rise_o   = d_out & ~hist_reg;
  assign fall_o   = ~d_out & hist_reg;
  assign change_o = |(rise_o | fall_o);

  a_no_dual_edge : assert property (@(posedge clk) disable iff (!rstn) (rise_o & fall_o) == '0)
    else $error("dc_sync_filter: rise and fall asserted on the same bit");

endmodule

// File: tb/tb_dc_sync_filter.sv
// Scoreboard bench for dc_sync_filter: an unfiltered 3-stage instance and a 2-stage instance
// with a 4-cycle persistence filter, both checked against a sample-history reference model.
module tb_dc_sync_filter;

  typedef struct packed {
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       change;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [3:0] din_a, din_b;
  logic [3:0] d_out_a, rise_a, fall_a;
  logic [3:0] d_out_b, rise_b, fall_b;
  logic       change_a, change_b;

  int checks = 0;
  int errors = 0;

  dc_sync_filter #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'hA), .FILTER_CYCLES(0)) u_a (
    .clk(clk), .rstn(rstn), .d_in(din_a),
    .d_out(d_out_a), .rise_o(rise_a), .fall_o(fall_a), .change_o(change_a)
  );

  dc_sync_filter #(.WIDTH(4), .STAGES(2), .RESET_VALUE(4'h0), .FILTER_CYCLES(4)) u_b (
    .clk(clk), .rstn(rstn), .d_in(din_b),
    .d_out(d_out_b), .rise_o(rise_b), .fall_o(fall_b), .change_o(change_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a delay line of d_in samples, plus a history of synced samples.
  // With a filter of N, an output bit flips when the last N synced samples all disagree with it.
  int         m_stages [2] = '{3, 2};
  int         m_filt   [2] = '{0, 4};
  logic [3:0] m_rv     [2] = '{4'hA, 4'h0};
  logic [3:0] m_chain  [2][8];
  logic [3:0] m_hist   [2][16];
  int         m_hcnt   [2];
  logic [3:0] m_dout   [2];
  logic [3:0] m_h      [2];

  exp_t sb_a[$];
  exp_t sb_b[$];

  task automatic model_edge(input int m, input logic [3:0] din, input logic rst_n, output exp_t e);
    logic [3:0] synced_prev;
    logic [3:0] h_new;
    logic       all_diff;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) m_chain[m][k] = m_rv[m];
      m_hcnt[m] = 0;
      m_dout[m] = m_rv[m];
      m_h[m]    = m_rv[m];
    end else begin
      synced_prev = m_chain[m][m_stages[m]-1];
      for (int j = 15; j > 0; j--) m_hist[m][j] = m_hist[m][j-1];
      m_hist[m][0] = synced_prev;
      if (m_hcnt[m] < 16) m_hcnt[m]++;
      h_new = m_dout[m];
      for (int k = 7; k > 0; k--) m_chain[m][k] = m_chain[m][k-1];
      m_chain[m][0] = din;
      if (m_filt[m] == 0) begin
        m_dout[m] = m_chain[m][m_stages[m]-1];
      end else begin
        for (int b = 0; b < 4; b++) begin
          all_diff = (m_hcnt[m] >= m_filt[m]);
          for (int j = 0; j < m_filt[m]; j++)
            if (m_hist[m][j][b] == m_dout[m][b]) all_diff = 1'b0;
          if (all_diff) m_dout[m][b] = ~m_dout[m][b];
        end
      end
      m_h[m] = h_new;
    end
    e.dout   = m_dout[m];
    e.rise   = m_dout[m] & ~m_h[m];
    e.fall   = ~m_dout[m] & m_h[m];
    e.change = |(e.rise | e.fall);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Pulse counters used by the directed phases.
  int rise_a0_cnt, change_a_cnt, rise_b1_cnt, fall_b1_cnt, change_b_cnt;

  exp_t ea, eb;
  always @(posedge clk) begin
    #1;
    if (sb_a.size() > 0) begin
      ea = sb_a.pop_front();
      chk("a_dout", d_out_a, ea.dout);
      chk("a_rise", rise_a, ea.rise);
      chk("a_fall", fall_a, ea.fall);
      chk("a_change", {3'b0, change_a}, {3'b0, ea.change});
    end
    if (sb_b.size() > 0) begin
      eb = sb_b.pop_front();
      chk("b_dout", d_out_b, eb.dout);
      chk("b_rise", rise_b, eb.rise);
      chk("b_fall", fall_b, eb.fall);
      chk("b_change", {3'b0, change_b}, {3'b0, eb.change});
    end
    if (rise_a[0]) rise_a0_cnt++;
    if (change_a)  change_a_cnt++;
    if (rise_b[1]) rise_b1_cnt++;
    if (fall_b[1]) fall_b1_cnt++;
    if (change_b)  change_b_cnt++;
  end

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic r);
    exp_t e;
    @(negedge clk);
    rstn  = r;
    din_a = a;
    din_b = b;
    model_edge(0, a, r, e);
    sb_a.push_back(e);
    model_edge(1, b, r, e);
    sb_b.push_back(e);
  endtask

  task automatic hold(input logic [3:0] a, input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 1'b1);
  endtask

  task automatic clear_counts();
    rise_a0_cnt = 0; change_a_cnt = 0; rise_b1_cnt = 0; fall_b1_cnt = 0; change_b_cnt = 0;
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rr;
    rstn  = 1'b0;
    din_a = 4'hA;
    din_b = 4'h0;
    clear_counts();

    // Reset held, then release with inputs equal to the reset value.
    for (int i = 0; i < 4; i++) step(4'hA, 4'h0, 1'b0);
    #1;
    chk("reset_dout_a", d_out_a, 4'hA);
    chk("reset_rise_a", rise_a, 4'h0);
    clear_counts();
    hold(4'hA, 4'h0, 10);
    chk("no_pulse_after_release_a", change_a_cnt[3:0], 4'd0);
    chk("no_pulse_after_release_b", change_b_cnt[3:0], 4'd0);

    // Latency: bit 0 of the unfiltered instance rises.
    clear_counts();
    hold(4'hB, 4'h0, 8);
    chk("latency_rise_a0_count", rise_a0_cnt[3:0], 4'd1);

    // Filter reject: a 3-cycle high on bit 1 never reaches d_out.
    clear_counts();
    hold(4'hB, 4'h2, 3);
    hold(4'hB, 4'h0, 10);
    chk("reject_rise_b1", rise_b1_cnt[3:0], 4'd0);
    chk("reject_fall_b1", fall_b1_cnt[3:0], 4'd0);

    // Filter pass in both directions.
    clear_counts();
    hold(4'hB, 4'h2, 12);
    chk("pass_rise_b1", rise_b1_cnt[3:0], 4'd1);
    hold(4'hB, 4'h0, 12);
    chk("pass_fall_b1", fall_b1_cnt[3:0], 4'd1);

    // Glitch restart: 3 high, 1 low, then a long high run.
    clear_counts();
    hold(4'hB, 4'h2, 3);
    hold(4'hB, 4'h0, 1);
    hold(4'hB, 4'h2, 10);
    chk("glitch_rise_b1", rise_b1_cnt[3:0], 4'd1);
    hold(4'hB, 4'h0, 12);

    // All bits changing together.
    hold(4'h0, 4'h0, 6);
    clear_counts();
    hold(4'hF, 4'hF, 12);
    chk("multi_change_a", change_a_cnt[3:0], 4'd1);
    chk("multi_change_b", change_b_cnt[3:0], 4'd1);
    hold(4'hF, 4'h0, 12);

    // Reset in the middle of a filter count.
    hold(4'hF, 4'hF, 3);
    step(4'hF, 4'hF, 1'b0);
    #1;
    chk("async_reset_dout_a", d_out_a, 4'hA);
    chk("async_reset_dout_b", d_out_b, 4'h0);
    step(4'hF, 4'hF, 1'b0);
    clear_counts();
    hold(4'hF, 4'hF, 12);
    chk("midreset_change_b", change_b_cnt[3:0], 4'd1);

    // Randomized levels with slow toggling and occasional resets.
    ra = 4'hF;
    rb = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) ra[b] = ~ra[b];
        if ($urandom_range(0, 4) == 0) rb[b] = ~rb[b];
      end
      rr = ($urandom_range(0, 399) != 0);
      step(ra, rb, rr);
    end

    hold(ra, rb, 2);
    @(posedge clk);
    #2;
    chk("scoreboard_drained_a", 4'(sb_a.size()), 4'd0);
    chk("scoreboard_drained_b", 4'(sb_b.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
